// File: rtl/seq_op_engine.sv
// -----------------------------------------------------------------------------
// seq_op_engine
//
// Purpose:
//   Programmable operand engine. Two N-bit operands arrive in W-bit chunks
//   (LSB chunk first), then a stored program of up to DEPTH 3-bit opcodes
//   runs on an N-bit accumulator, one op per cycle. The accumulator is then
//   streamed out in W-bit chunks under consumer backpressure.
//
// Handshakes (strict valid/ready):
//   A transfer happens on a rising edge where valid and ready are both high.
//   in_ready depends only on state, and out_valid depends only on state.
//   Neither depends on the partner's valid or ready, so no combinational loop
//   can form. While out_valid is high and out_ready is low, out_data and
//   out_last hold stable.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start, i_abort      begin a run (IDLE only) / return to IDLE from anywhere
//   i_prog_we/addr/op     program slot write (IDLE only)
//   i_prog_len            ops to run, sampled with start, clamped to DEPTH
//   i_in_valid, o_in_ready, i_a, i_b           operand chunk stream
//   o_out_valid, i_out_ready, o_out_data, o_out_last   result chunk stream
//   o_busy, o_done, o_state  status; o_state is the FSM state for debug
// -----------------------------------------------------------------------------
module seq_op_engine #(
    parameter int N     = 64,
    parameter int W     = 4,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_prog_we,
    input  logic [AW-1:0] i_prog_addr,
    input  logic [2:0]    i_prog_op,
    input  logic [AW:0]   i_prog_len,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [W-1:0]  o_out_data,
    output logic          o_out_last,
    output logic          o_busy,
    output logic          o_done,
    output logic [1:0]    o_state
);

    localparam int C  = N / W;
    localparam int KW = $clog2(C);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_EXEC  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [C-1:0][W-1:0]   r_a;
    logic [C-1:0][W-1:0]   r_b;
    logic [C-1:0][W-1:0]   r_acc;
    logic [DEPTH-1:0][2:0] r_prog;
    logic [KW-1:0]         r_k;
    logic [AW-1:0]         r_s;
    logic [AW:0]           r_len;
    logic                  r_done;

    logic                  w_start_run;
    logic                  w_load_beat;
    logic                  w_exec_step;
    logic                  w_drain_xfer;
    logic                  w_k_last;
    logic                  w_s_last;
    logic [AW:0]           w_len_clamped;
    logic [N-1:0]          w_op_result;

    // Operation set. All compares unsigned; results truncated to N bits.
    function automatic logic [N-1:0] f_op(
        input logic [2:0]   op,
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic [N-1:0] c
    );
        logic [N:0]   sum;
        logic [N-1:0] mn;
        logic [N-1:0] mx;
        logic [N-1:0] res;
        sum = {1'b0, a} + {1'b0, b};
        mn  = (a < b) ? a : b;
        mx  = (a < b) ? b : a;
        res = '0;
        case (op)
            3'd0:    res = (a & b) | c;
            3'd1:    res = (a ^ b) + c;
            3'd2:    res = (mx - mn) ^ c;
            3'd3:    res = {c[N-1:N/2], mn[N/2-1:0]};
            3'd4:    res = mx + {c[N-2:0], 1'b0};
            // Carry out of the N+1-bit sum saturates to all ones.
            3'd5:    res = (sum[N] ? {N{1'b1}} : sum[N-1:0]) & c;
            // Overflow-free floor average of A and B.
            3'd6:    res = ((a & b) + ((a ^ b) >> 1)) | c;
            3'd7:    res = {a[N-2:0], a[N-1]} ^ b ^ c;
            default: res = '0;
        endcase
        return res;
    endfunction

    assign w_len_clamped = (i_prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_prog_len;
    assign w_k_last      = (r_k == KW'(C - 1));
    assign w_s_last      = ({1'b0, r_s} == (r_len - 1'b1));
    assign w_op_result   = f_op(r_prog[r_s], r_a, r_b, r_acc);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, handshake outputs and datapath strobes
    always_comb begin
        w_next_state = r_state;
        w_start_run  = 1'b0;
        w_load_beat  = 1'b0;
        w_exec_step  = 1'b0;
        w_drain_xfer = 1'b0;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        o_out_data   = '0;
        o_out_last   = 1'b0;
        o_busy       = (r_state != S_IDLE);
        o_state      = r_state;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start_run  = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_load_beat = 1'b1;
                    if (w_k_last) begin
                        w_next_state = (r_len != '0) ? S_EXEC : S_DRAIN;
                    end
                end
            end
            S_EXEC: begin
                w_exec_step = 1'b1;
                if (w_s_last) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_out_valid = 1'b1;
                o_out_data  = r_acc[r_k];
                o_out_last  = w_k_last;
                if (i_out_ready) begin
                    w_drain_xfer = 1'b1;
                    if (w_k_last) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        // Abort overrides every strobe so nothing in the datapath moves.
        if (i_abort) begin
            w_next_state = S_IDLE;
            w_start_run  = 1'b0;
            w_load_beat  = 1'b0;
            w_exec_step  = 1'b0;
            w_drain_xfer = 1'b0;
        end
    end

    // Datapath: operands, accumulator, counters, done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_k    <= '0;
            r_s    <= '0;
            r_len  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_drain_xfer & w_k_last;
            if (i_abort) begin
                r_k <= '0;
                r_s <= '0;
            end else begin
                if (w_start_run) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_acc <= '0;
                    r_k   <= '0;
                    r_s   <= '0;
                    r_len <= w_len_clamped;
                end
                // C is a power of two, so k wraps to 0 after the last chunk,
                // leaving it ready for the drain phase.
                if (w_load_beat) begin
                    r_a[r_k] <= i_a;
                    r_b[r_k] <= i_b;
                    r_k      <= r_k + 1'b1;
                end
                if (w_exec_step) begin
                    r_acc <= w_op_result;
                    r_s   <= r_s + 1'b1;
                end
                if (w_drain_xfer) begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    // Program store. Writes are taken only while idle. Because the write
    // lands on the same edge as start, a run started in that cycle uses
    // the new opcode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prog <= '0;
        end else if (i_prog_we && (r_state == S_IDLE) && !i_abort) begin
            r_prog[i_prog_addr] <= i_prog_op;
        end
    end

    assign o_done = r_done;

endmodule
